// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 4-bit ALU among NUM_REQ requesters
module alu_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_A,
    input  logic [4*NUM_REQ-1:0]   req_B,
    input  logic [2*NUM_REQ-1:0]   req_Func,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_id,
    output logic [7:0]             ALUout,
    output logic                   busy
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state;
    logic [1:0]           rr_ptr;
    logic [1:0]           grant;
    logic [1:0]           next_rr;
    logic                 found;
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [2*NUM_REQ-1:0] valid_rot;
    logic [2:0]           sum;
    logic [3:0]           sel_a;
    logic [3:0]           sel_b;
    logic [1:0]           sel_func;
    logic [3:0]           op_a;
    logic [3:0]           op_b;
    logic [1:0]           op_func;
    logic [1:0]           op_id;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           alu_res;

    // Rotate the request vector so bit k is requester (rr_ptr+k) mod NUM_REQ; lowest k wins.
    always_comb begin
        valid_dbl = {req_valid, req_valid};
        valid_rot = valid_dbl >> rr_ptr;
        grant     = rr_ptr;
        found     = 1'b0;
        sum       = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                sum = 3'(rr_ptr) + 3'(k);
                if (sum >= 3'(NUM_REQ)) begin
                    sum = sum - 3'(NUM_REQ);
                end
                grant = sum[1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a    = 4'd0;
        sel_b    = 4'd0;
        sel_func = 2'd0;
        next_rr  = grant + 2'd1;
        if (3'(grant) + 3'd1 >= 3'(NUM_REQ)) begin
            next_rr = 2'd0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = Resetn && (state == IDLE) && found && (grant == 2'(i));
            if (grant == 2'(i)) begin
                sel_a    = req_A[4*i +: 4];
                sel_b    = req_B[4*i +: 4];
                sel_func = req_Func[2*i +: 2];
            end
        end
    end

    always_comb begin
        case (op_func)
            2'd0:    alu_res = {3'b000, {1'b0, op_a} + {1'b0, op_b}};
            2'd1:    alu_res = {7'd0, |{op_a, op_b}};
            2'd2:    alu_res = {7'd0, &{op_a, op_b}};
            default: alu_res = {op_a, op_b};
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            rr_ptr     <= 2'd0;
            resp_valid <= 1'b0;
            resp_id    <= 2'd0;
            ALUout     <= 8'd0;
            op_a       <= 4'd0;
            op_b       <= 4'd0;
            op_func    <= 2'd0;
            op_id      <= 2'd0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_func <= sel_func;
                        op_id   <= grant;
                        rr_ptr  <= next_rr;
                        cnt     <= '0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        ALUout     <= alu_res;
                        resp_id    <= op_id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - bench for alu_arbiter: directed cases plus random traffic against a transaction model
module tb_alu_arbiter;

    localparam int N  = 3;
    localparam int EC = 2;

    logic           Clock = 1'b0;
    logic           Resetn;
    logic [N-1:0]   req_valid;
    logic [4*N-1:0] req_A;
    logic [4*N-1:0] req_B;
    logic [2*N-1:0] req_Func;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [7:0]     ALUout;
    logic           busy;

    alu_arbiter #(.NUM_REQ(N), .EXEC_CYCLES(EC)) dut (
        .Clock(Clock), .Resetn(Resetn), .req_valid(req_valid), .req_A(req_A),
        .req_B(req_B), .req_Func(req_Func), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .ALUout(ALUout), .busy(busy)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_m(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
        case (f)
            2'd0:    return 8'(int'(a) + int'(b));
            2'd1:    return ({a, b} != 8'd0) ? 8'd1 : 8'd0;
            2'd2:    return ({a, b} == 8'hFF) ? 8'd1 : 8'd0;
            default: return 8'(int'(a) * 16 + int'(b));
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    // Transaction-level model: countdown to result, pending response flag, rotating priority.
    int           m_rr = 0;
    int           m_left = 0;
    bit           m_resp = 0;
    logic [7:0]   m_out = 8'd0;
    logic [7:0]   m_pres = 8'd0;
    logic [1:0]   m_id = 2'd0;
    logic [1:0]   m_pid = 2'd0;
    logic [N-1:0] acc_mask = '0;

    always @(negedge Clock) begin : cmp
        logic [N-1:0] exp_rdy;
        int g;
        bit busy_m;
        if (!Resetn) begin
            m_rr = 0; m_left = 0; m_resp = 0; m_out = 8'd0; m_id = 2'd0;
            acc_mask = '0;
            chk("reset_outputs", 32'({req_ready, resp_valid, resp_id, ALUout, busy}), 32'd0);
        end else begin
            busy_m = (m_left > 0) || m_resp;
            g = busy_m ? -1 : pick(req_valid, m_rr);
            exp_rdy = (g >= 0) ? N'(1) << g : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(busy_m));
            chk("resp_valid", 32'(resp_valid), 32'(m_resp));
            chk("ALUout", 32'(ALUout), 32'(m_out));
            chk("resp_id", 32'(resp_id), 32'(m_id));
            acc_mask = req_ready & req_valid;
            if (g >= 0) begin
                m_pres = alu_m(req_A[4*g +: 4], req_B[4*g +: 4], req_Func[2*g +: 2]);
                m_pid  = 2'(g);
                m_rr   = (g + 1) % N;
                m_left = EC;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_resp = 1; m_out = m_pres; m_id = m_pid;
                end
            end else if (m_resp && resp_ready) begin
                m_resp = 0;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
        req_A[4*i +: 4]    = a;
        req_B[4*i +: 4]    = b;
        req_Func[2*i +: 2] = f;
    endtask

    task automatic wait_grant(input int id);
        for (int c = 0; c < 100; c++) begin
            @(negedge Clock);
            if (req_ready[id]) begin
                tick();
                return;
            end
        end
        chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        for (int c = 0; c < 100; c++) begin
            if (resp_valid) return;
            tick();
            lat++;
        end
        chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            if (!busy) return;
            tick();
        end
        chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] f,
                         output logic [7:0] res, output logic [1:0] rid, output int lat);
        set_req(id, a, b, f);
        req_valid[id] = 1'b1;
        resp_ready = 1'b1;
        wait_grant(id);
        req_valid[id] = 1'b0;
        wait_resp(lat);
        res = ALUout;
        rid = resp_id;
        tick();
    endtask

    logic [7:0] res;
    logic [1:0] rid;
    int         lat;

    initial begin
        Resetn = 1'b0; req_valid = '0; req_A = '0; req_B = '0; req_Func = '0; resp_ready = 1'b0;

        chk("model_add", 32'(alu_m(4'hF, 4'h1, 2'd0)), 32'h10);
        chk("model_or0", 32'(alu_m(4'h0, 4'h0, 2'd1)), 32'h00);
        chk("model_or1", 32'(alu_m(4'h0, 4'h8, 2'd1)), 32'h01);
        chk("model_and", 32'(alu_m(4'hF, 4'hE, 2'd2)), 32'h00);
        chk("model_cat", 32'(alu_m(4'hA, 4'hC, 2'd3)), 32'hAC);
        chk("model_pick", 32'(pick(3'b011, 1)), 32'd1);
        chk("model_pick_wrap", 32'(pick(3'b001, 1)), 32'd0);

        for (int c = 0; c < 8; c++) begin
            tick();
            req_valid = N'($urandom);
            #1;
            chk("reset_hold", 32'({req_ready, resp_valid, resp_id, ALUout, busy}), 32'd0);
        end
        tick();
        req_valid = '0;
        Resetn = 1'b1;
        tick();

        do_op(0, 4'hF, 4'h1, 2'd0, res, rid, lat);
        chk("add_result", 32'(res), 32'h10);
        chk("add_id", 32'(rid), 32'd0);
        chk("add_latency", 32'(lat), 32'(EC));

        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        set_req(0, 4'h3, 4'h5, 2'd3);
        set_req(1, 4'hA, 4'hC, 2'd3);
        req_valid = 3'b011;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_resp(lat);
            chk("rr_id", 32'(resp_id), 32'(k % 2));
            chk("rr_result", 32'(ALUout), (k % 2 == 0) ? 32'h35 : 32'hAC);
            tick();
        end
        req_valid = '0;
        wait_idle();

        set_req(0, 4'hF, 4'hF, 2'd2);
        req_valid[0] = 1'b1;
        resp_ready = 1'b0;
        wait_grant(0);
        req_valid[0] = 1'b0;
        set_req(1, 4'h1, 4'h2, 2'd0);
        req_valid[1] = 1'b1;
        wait_resp(lat);
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold", 32'({ALUout, resp_valid, busy, req_ready}), 32'({8'h01, 1'b1, 1'b1, 3'b000}));
            tick();
        end
        resp_ready = 1'b1;
        req_valid[1] = 1'b0;
        tick();
        chk("bp_release", 32'({resp_valid, busy}), 32'd0);

        do_op(1, 4'h0, 4'h0, 2'd1, res, rid, lat);
        chk("or_zero", 32'(res), 32'h00);
        do_op(0, 4'h0, 4'h8, 2'd1, res, rid, lat);
        chk("or_one", 32'(res), 32'h01);
        do_op(1, 4'hF, 4'hE, 2'd2, res, rid, lat);
        chk("and_zero", 32'(res), 32'h00);
        do_op(0, 4'h5, 4'hA, 2'd3, res, rid, lat);
        chk("cat_5a", 32'(res), 32'h5A);

        set_req(0, 4'h1, 4'h1, 2'd0);
        req_valid[0] = 1'b1;
        wait_grant(0);
        req_valid[0] = 1'b0;
        Resetn = 1'b0;
        #1;
        chk("midop_reset", 32'({req_ready, resp_valid, resp_id, ALUout, busy}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midop_no_resp", 32'(resp_valid), 32'd0);
        end
        Resetn = 1'b1;
        set_req(0, 4'h2, 4'h2, 2'd0);
        set_req(1, 4'h3, 4'h3, 2'd0);
        req_valid = 3'b011;
        @(negedge Clock);
        chk("post_reset_grant", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        wait_resp(lat);
        chk("post_reset_result", 32'({resp_id, ALUout}), 32'({2'd0, 8'h04}));
        tick();
        wait_idle();

        for (int c = 0; c < 3000; c++) begin
            tick();
            Resetn = ($urandom_range(0, 499) != 0);
            resp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                    set_req(i, 4'($urandom), 4'($urandom), 2'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        Resetn = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
